// File: rtl/sram_req_if.sv
// Request/response bundle between a requester and sram_req_ctrl.
// The master issues requests and consumes read responses.
interface sram_req_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W/8-1:0] req_mask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr,
    output req_data, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_data, req_mask, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// Request front-end for a 1R1W SRAM: writes pass straight through,
// reads are tracked and queued in a small in-order response FIFO.
module sram_req_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  sram_req_if.slave           bus,
  output logic                mem_w_en,
  output logic [ADDR_W-1:0]   mem_w_addr,
  output logic [DATA_W-1:0]   mem_w_data,
  output logic [DATA_W/8-1:0] mem_w_mask,
  output logic                mem_r_en,
  output logic [ADDR_W-1:0]   mem_r_addr,
  input  logic [DATA_W-1:0]   mem_r_data
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [DATA_W-1:0] fifo_q [RESP_DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic              inflight_q;
  logic [CW-1:0]     occ;
  logic              rd_room;
  logic              wr_acc;
  logic              rd_acc;
  logic              enq;
  logic              deq;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Room is judged on registered occupancy only, so resp_ready
  // never reaches req_ready combinationally.
  assign occ     = count_q + CW'(inflight_q);
  assign rd_room = occ < CW'(RESP_DEPTH);

  assign bus.req_ready = !reset && (bus.req_write || rd_room);

  assign wr_acc = bus.req_valid && bus.req_ready && bus.req_write;
  assign rd_acc = bus.req_valid && bus.req_ready && !bus.req_write;

  assign mem_w_en   = wr_acc;
  assign mem_w_addr = bus.req_addr;
  assign mem_w_data = bus.req_data;
  assign mem_w_mask = bus.req_mask;
  assign mem_r_en   = rd_acc;
  assign mem_r_addr = bus.req_addr;

  assign enq = inflight_q;
  assign deq = bus.resp_valid && bus.resp_ready;

  assign bus.resp_valid = (count_q != '0);
  assign bus.resp_data  = fifo_q[head_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_acc;
      if (enq) tail_q <= nxt(tail_q);
      if (deq) head_q <= nxt(head_q);
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives in count_q.
  always_ff @(posedge clock) begin
    if (enq) fifo_q[tail_q] <= mem_r_data;
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
    occ <= CW'(RESP_DEPTH)
  );
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a masked 1R1W SRAM model.
// Inputs change 1 time unit after each rising edge.
module tb_sram_req_ctrl;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          mem_w_en;
  logic [AW-1:0] mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic [3:0]    mem_w_mask;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data;

  logic [DW-1:0] sram [2**AW];

  int total = 0;
  int bad   = 0;
  int acc   = 0;

  sram_req_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_req_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_w_mask (mem_w_mask),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_w_en)
      for (int b = 0; b < 4; b++)
        if (mem_w_mask[b])
          sram[mem_w_addr][b*8 +: 8] <= mem_w_data[b*8 +: 8];
    if (mem_r_en) mem_r_data <= sram[mem_r_addr];
  end

  function automatic logic [DW-1:0] pre(input int a);
    return 32'hC0DE_0000 | a;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic v, input logic w,
                     input int a, input logic [31:0] d,
                     input logic [3:0] m);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = AW'(a);
    bus.req_data  = d;
    bus.req_mask  = m;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) sram[i] = pre(i);
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    drv(1'b1, 1'b1, 3, 32'h1234_5678, 4'hF);
    cyc();
    cyc();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_w_en", mem_w_en, 0);
    bus.req_write = 1'b0;
    #1;
    chk("rst_r_en", mem_r_en, 0);
    idle();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.req_ready, 1);
    chk("idle_w_en", mem_w_en, 0);
    chk("idle_r_en", mem_r_en, 0);

    // write then read 0x005
    cyc();
    drv(1'b1, 1'b1, 5, 32'hA5A5_A5A5, 4'hF);
    #1;
    chk("w5_ready", bus.req_ready, 1);
    chk("w5_w_en", mem_w_en, 1);
    chk("w5_addr", mem_w_addr, 5);
    chk("w5_data", mem_w_data, 32'hA5A5_A5A5);
    chk("w5_mask", mem_w_mask, 4'hF);
    chk("w5_r_en", mem_r_en, 0);
    cyc();
    drv(1'b1, 1'b0, 5, 32'h0, 4'h0);
    #1;
    chk("r5_ready", bus.req_ready, 1);
    chk("r5_r_en", mem_r_en, 1);
    chk("r5_r_addr", mem_r_addr, 5);
    chk("r5_w_en", mem_w_en, 0);
    chk("w_no_resp", bus.resp_valid, 0);
    cyc();
    idle();
    #1;
    chk("r5_t1_valid", bus.resp_valid, 0);
    cyc();
    chk("r5_t2_valid", bus.resp_valid, 1);
    chk("r5_t2_data", bus.resp_data, 32'hA5A5_A5A5);
    cyc();
    chk("r5_drained", bus.resp_valid, 0);

    // masked write, read right after the second write
    drv(1'b1, 1'b1, 7, 32'h1122_3344, 4'hF);
    cyc();
    drv(1'b1, 1'b1, 7, 32'hFFFF_FFFF, 4'h2);
    cyc();
    drv(1'b1, 1'b0, 7, 32'h0, 4'h0);
    cyc();
    idle();
    cyc();
    chk("mask_valid", bus.resp_valid, 1);
    chk("mask_data", bus.resp_data, 32'h1122_FF44);
    cyc();

    // backpressure: 3 accepted, 4th held off
    bus.resp_ready = 1'b0;
    drv(1'b1, 1'b0, 16, 32'h0, 4'h0);
    #1;
    chk("bp0_ready", bus.req_ready, 1);
    cyc();
    drv(1'b1, 1'b0, 17, 32'h0, 4'h0);
    #1;
    chk("bp1_ready", bus.req_ready, 1);
    cyc();
    drv(1'b1, 1'b0, 18, 32'h0, 4'h0);
    #1;
    chk("bp2_ready", bus.req_ready, 1);
    cyc();
    drv(1'b1, 1'b0, 19, 32'h0, 4'h0);
    #1;
    chk("bp3_ready_a", bus.req_ready, 0);
    chk("bp3_r_en_a", mem_r_en, 0);
    cyc();
    chk("bp3_ready_b", bus.req_ready, 0);
    chk("bp_head_v", bus.resp_valid, 1);
    chk("bp_head_d", bus.resp_data, pre(16));
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", bus.req_ready, 0);
    cyc();
    chk("bp3_ready_c", bus.req_ready, 1);
    chk("bp3_r_en_c", mem_r_en, 1);
    chk("bp_d17", bus.resp_data, pre(17));
    cyc();
    idle();
    chk("bp_d18", bus.resp_data, pre(18));
    cyc();
    chk("bp_v19", bus.resp_valid, 1);
    chk("bp_d19", bus.resp_data, pre(19));
    cyc();
    chk("bp_empty", bus.resp_valid, 0);

    // 10 back-to-back reads, responses lag by 2
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drv(1'b1, 1'b0, 32 + i, 32'h0, 4'h0);
      else idle();
      #1;
      if (i < 10) begin
        chk($sformatf("b2b_rdy%0d", i), bus.req_ready, 1);
        if (mem_r_en) acc++;
      end
      if (i >= 2) begin
        chk($sformatf("b2b_v%0d", i - 2), bus.resp_valid, 1);
        chk($sformatf("b2b_d%0d", i - 2),
            bus.resp_data, pre(32 + i - 2));
      end else begin
        chk($sformatf("b2b_nv%0d", i), bus.resp_valid, 0);
      end
      cyc();
    end
    chk("b2b_accepts", acc, 10);
    chk("b2b_empty", bus.resp_valid, 0);

    // reset with 2 queued + 1 inflight
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 48 + i, 32'h0, 4'h0);
      cyc();
    end
    idle();
    #1;
    chk("pre_rst_valid", bus.resp_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.resp_valid, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    cyc();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    #1;
    chk("rel_ready", bus.req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("no_stale%0d", i), bus.resp_valid, 0);
    end
    drv(1'b1, 1'b0, 5, 32'h0, 4'h0);
    cyc();
    idle();
    cyc();
    chk("new_rd_valid", bus.resp_valid, 1);
    chk("new_rd_data", bus.resp_data, 32'hA5A5_A5A5);
    cyc();
    chk("final_empty", bus.resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 Parameters: ADDR_W, default 11, word address width; DATA_W, default 32, data width; RESP_DEPTH, default 3, read-response FIFO entries (legal range 2..8).
REQ-002 The write mask width SHALL be DATA_W/8 bits, one bit per byte lane.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clock  in  1  single clock for all logic; the attached SRAM's W0_clk and R0_clk are tied to it
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_data  in  DATA_W  write data
- req_mask  in  DATA_W/8  byte-enable for writes
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes resp_data when resp_valid && resp_ready
- resp_data  out  DATA_W  read data
- mem_w_en / mem_w_addr / mem_w_data / mem_w_mask  out  1/ADDR_W/DATA_W/DATA_W/8  to SRAM W0 port
- mem_r_en / mem_r_addr  out  1/ADDR_W  to SRAM R0 port
- mem_r_data  in  DATA_W  SRAM R0 data, valid the cycle after mem_r_en
REQ-004 Clock is clock; reset is asynchronous and active-high, named reset.

Function
REQ-005 Write accept: req_ready SHALL be 1 for writes whenever reset is low; on accept, mem_w_en=1 with addr/data/mask driven combinationally from req_* in the same cycle.
REQ-006 Writes SHALL produce no response.
REQ-007 Read accept: req_ready for reads SHALL be 1 iff (fifo_count + inflight) < RESP_DEPTH, computed from registered state only (no path from resp_ready to req_ready).
REQ-008 On read accept, mem_r_en=1 and mem_r_addr=req_addr in the same cycle; inflight SHALL be 1 in the following cycle.
REQ-009 mem_w_en and mem_r_en SHALL be 0 in any cycle without an accepted request of that type.
REQ-010 In the cycle after a read accept, mem_r_data SHALL be written into the FIFO tail at the clock edge; inflight clears unless a new read was accepted that cycle.
REQ-011 Read latency: resp_valid SHALL assert exactly 2 cycles after the accept cycle when the FIFO was empty.
REQ-012 FIFO: circular pointers of width clog2(RESP_DEPTH), wrapping at RESP_DEPTH-1 -> 0; resp_valid = (fifo_count != 0); resp_data = head entry.
REQ-013 Simultaneous enqueue and dequeue SHALL leave fifo_count unchanged; dequeue from an empty FIFO SHALL be impossible.
REQ-014 With resp_ready held 1, back-to-back reads SHALL sustain one accept per cycle (requires RESP_DEPTH>=3).
REQ-015 Responses SHALL be returned in request order.
REQ-016 A read accepted the cycle after a write to the same address SHALL return the new data; ordering follows the SRAM's write-then-read timing.
REQ-017 Overflow is impossible by construction; an assertion SHALL check fifo_count + inflight <= RESP_DEPTH.

Reset
REQ-018 While reset=1: req_ready=0, resp_valid=0, mem_w_en=0, mem_r_en=0; fifo_count, pointers and inflight cleared asynchronously.
REQ-019 FIFO data storage SHALL NOT be reset.
REQ-020 Reset asserted mid-operation SHALL discard all inflight and queued responses; no stale response appears after release.
REQ-021 req_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-022 Write addr 0x005, data 0xA5A5A5A5, mask 0xF; then read 0x005 -> resp_valid 2 cycles after the read accept, resp_data 0xA5A5A5A5.
REQ-023 Write 0x11223344 to addr 7, then write 0xFFFFFFFF with mask 0x2; read addr 7 -> 0x1122FF44.
REQ-024 Hold resp_ready=0 and issue 4 reads -> 3 accepted, req_ready=0 on the 4th; release resp_ready -> responses in order, then the 4th is accepted.
REQ-025 Issue 10 back-to-back reads with resp_ready=1 -> 10 accepts in 10 consecutive cycles, 10 in-order responses; FIFO pointers wrap correctly.
REQ-026 Assert reset with 2 responses queued and 1 inflight -> resp_valid=0 immediately; after release, no response until a new read is issued.
REQ-027 Write at cycle t, then read of the same address at t+1 -> response carries the data written at t.
